// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    // Width of a down-counter that must hold the longer of the two phase lengths.
    function automatic int unsigned cnt_width(input int unsigned on_cycles,
                                              input int unsigned off_cycles);
        int unsigned longest;
        longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/pulse_stretcher_event_counter.sv
// Saturating up/down count of deferred events, with synchronous flush and registered full flag.
module pulse_event_counter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = $clog2(DEPTH + 1)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         flush_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         full_o
);

    logic [W-1:0] count_q, count_d;
    logic         full_q;

    // Simultaneous inc and dec cancel out; flush wins over everything.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i && (count_q != W'(DEPTH))) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == W'(DEPTH));
        end
    end

    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON_CYCLES-high / OFF_CYCLES-low pulses.
// Define PULSE_STRETCHER_QUEUE_EN to defer events arriving mid-pulse instead of dropping them.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = 16,
    parameter int unsigned OFF_CYCLES  = 16,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned PEND_BITS   = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 event_in,
    input  logic                 enable_in,
    output logic                 signal_out,
    output logic                 busy_out,
    output logic                 overflow_out,
    output logic [PEND_BITS-1:0] pending_out
);

    localparam int unsigned CNT_W = cnt_width(ON_CYCLES, OFF_CYCLES);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 signal_q, busy_q, ovf_q;
    logic                 accept_c, last_c, off_end_c, active_c;
    logic                 restart_c, ovf_c;
    logic                 queue_full_c, pend_avail_c;
    logic [PEND_BITS-1:0] pending_c;

    assign accept_c  = event_in & enable_in;
    assign last_c    = (cnt_q == '0);
    assign active_c  = (state_q != IDLE);
    assign off_end_c = (state_q == OFF) && last_c;

`ifdef PULSE_STRETCHER_QUEUE_EN
    localparam bit QUEUE_EN = 1'b1;

    logic inc_c, dec_c;

    // On the final OFF cycle an incoming event and a consumed entry cancel.
    assign inc_c = accept_c && active_c && (off_end_c || !queue_full_c);
    assign dec_c = off_end_c && restart_c;

    pulse_event_counter #(
        .DEPTH (QUEUE_DEPTH),
        .W     (PEND_BITS)
    ) u_pending (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .flush_i (!enable_in),
        .inc_i   (inc_c),
        .dec_i   (dec_c),
        .count_o (pending_c),
        .full_o  (queue_full_c)
    );

    assign pend_avail_c = enable_in && (pending_c != '0);
`else
    localparam bit QUEUE_EN = 1'b0;

    assign pending_c    = '0;
    assign queue_full_c = 1'b1;
    assign pend_avail_c = 1'b0;
`endif

    assign restart_c = pend_avail_c || (QUEUE_EN && accept_c);
    assign ovf_c     = accept_c && active_c && !(QUEUE_EN && (off_end_c || !queue_full_c));

    // Phase sequencing: each phase counts down from its length minus one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = ON;
                    cnt_d   = CNT_W'(ON_CYCLES - 1);
                end
            end
            ON: begin
                if (last_c) begin
                    state_d = OFF;
                    cnt_d   = CNT_W'(OFF_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OFF: begin
                if (last_c) begin
                    if (restart_c) begin
                        state_d = ON;
                        cnt_d   = CNT_W'(ON_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signal_q <= (state_d == ON);
            busy_q   <= (state_d != IDLE);
            ovf_q    <= ovf_c;
        end
    end

    assign signal_out   = signal_q;
    assign busy_out     = busy_q;
    assign overflow_out = ovf_q;
    assign pending_out  = pending_c;

endmodule
